// File: rtl/bus_interconnect_tmo_if.sv
// Bus bundle between one master, the interconnect and NumofSlave slaves.
// The slave modport is the interconnect's view; master is the opposite side.
interface bus_interconnect_tmo_if #(
  parameter int DWidth     = 32,
  parameter int NumofSlave = 4
);
  logic [DWidth-1:0]     addr_i;
  logic                  trans_i;
  logic [DWidth-1:0]     rdata_i [NumofSlave];
  logic [NumofSlave-1:0] resp_i;
  logic [NumofSlave-1:0] readyout_i;
  logic [NumofSlave-1:0] sel_o;
  logic [DWidth-1:0]     rdata_o;
  logic                  resp_o;
  logic                  ready_o;

  modport slave (
    input  addr_i, trans_i, rdata_i, resp_i, readyout_i,
    output sel_o, rdata_o, resp_o, ready_o
  );

  modport master (
    output addr_i, trans_i, rdata_i, resp_i, readyout_i,
    input  sel_o, rdata_o, resp_o, ready_o
  );
endinterface

// File: rtl/bus_interconnect_tmo.sv
// Single-master interconnect: mask/base address decode, data-phase response mux,
// built-in default slave with two-cycle ERROR, per-transfer wait timeout.
module bus_interconnect_tmo #(
  parameter int                           DWidth        = 32,
  parameter int                           NumofSlave    = 4,
  parameter logic [NumofSlave*DWidth-1:0] SlvBase       = '0,
  parameter logic [NumofSlave*DWidth-1:0] SlvMask       = '0,
  parameter int                           TimeoutCycles = 16,
  parameter int                           CntWidth      = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  bus_interconnect_tmo_if.slave bus,
  output logic [CntWidth-1:0]  err_cnt_o,
  output logic                 tmo_o
);

  // dsel encodes slaves 0..NumofSlave-1, then DEFAULT, then IDLE.
  localparam int SelW = $clog2(NumofSlave + 2);
  localparam logic [SelW-1:0] DselDefault = SelW'(NumofSlave);
  localparam logic [SelW-1:0] DselIdle    = SelW'(NumofSlave + 1);
  localparam int TmoW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  typedef enum logic [1:0] {StIdle, StActive, StErr1, StErr2} state_e;

  state_e              state_q, state_d;
  logic [SelW-1:0]     dsel_q, dsel_d;
  logic [TmoW-1:0]     wait_q, wait_d;
  logic                from_tmo_q, from_tmo_d;
  logic [CntWidth-1:0] err_cnt_q, err_cnt_d;

  logic                hit;
  logic [SelW-1:0]     hit_idx;
  logic                slv_ready;
  logic                slv_resp;
  logic [DWidth-1:0]   slv_rdata;
  logic                ready;
  logic                resp;
  logic [DWidth-1:0]   rdata;
  logic                accept;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NumofSlave - 1; i >= 0; i--) begin
      if ((bus.addr_i & SlvMask[i*DWidth +: DWidth]) == SlvBase[i*DWidth +: DWidth]) begin
        hit     = 1'b1;
        hit_idx = SelW'(i);
      end
    end
  end

  always_comb begin
    slv_ready = 1'b0;
    slv_resp  = 1'b0;
    slv_rdata = '0;
    for (int i = 0; i < NumofSlave; i++) begin
      if (dsel_q == SelW'(i)) begin
        slv_ready = bus.readyout_i[i];
        slv_resp  = bus.resp_i[i];
        slv_rdata = bus.rdata_i[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      dsel_q     <= DselIdle;
      wait_q     <= '0;
      from_tmo_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      dsel_q     <= dsel_d;
      wait_q     <= wait_d;
      from_tmo_q <= from_tmo_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dsel_d     = dsel_q;
    wait_d     = wait_q;
    from_tmo_d = from_tmo_q;
    err_cnt_d  = err_cnt_q;
    accept     = 1'b0;

    case (state_q)
      StIdle: accept = 1'b1;
      StActive: begin
        if (slv_ready) begin
          accept = 1'b1;
        end else if ((TimeoutCycles != 0) && (wait_q == TmoW'(TimeoutCycles - 1))) begin
          // Abandon the slave: dsel leaves its index so its late responses are ignored.
          state_d    = StErr1;
          dsel_d     = DselIdle;
          from_tmo_d = 1'b1;
        end else begin
          wait_d = wait_q + TmoW'(1);
        end
      end
      StErr1: state_d = StErr2;
      StErr2: begin
        accept = 1'b1;
        if (err_cnt_q != '1) begin
          err_cnt_d = err_cnt_q + CntWidth'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      wait_d     = '0;
      from_tmo_d = 1'b0;
      if (!bus.trans_i) begin
        state_d = StIdle;
        dsel_d  = DselIdle;
      end else if (hit) begin
        state_d = StActive;
        dsel_d  = hit_idx;
      end else begin
        state_d = StErr1;
        dsel_d  = DselDefault;
      end
    end
  end

  always_comb begin
    ready = 1'b1;
    resp  = 1'b0;
    rdata = '0;
    case (state_q)
      StIdle: begin
        ready = 1'b1;
        resp  = 1'b0;
      end
      StActive: begin
        ready = slv_ready;
        resp  = slv_resp;
        rdata = slv_rdata;
      end
      StErr1: begin
        ready = 1'b0;
        resp  = 1'b1;
      end
      StErr2: begin
        ready = 1'b1;
        resp  = 1'b1;
      end
      default: begin
        ready = 1'b1;
        resp  = 1'b0;
      end
    endcase
  end

  always_comb begin
    bus.sel_o = '0;
    for (int i = 0; i < NumofSlave; i++) begin
      bus.sel_o[i] = bus.trans_i & hit & (hit_idx == SelW'(i)) & ready;
    end
  end

  assign bus.ready_o = ready;
  assign bus.resp_o  = resp;
  assign bus.rdata_o = rdata;
  assign err_cnt_o   = err_cnt_q;
  assign tmo_o       = (state_q == StErr2) & from_tmo_q;

endmodule

// File: tb/tb_bus_interconnect_tmo.sv
// Directed bench: two interconnect instances share one stimulus stream
// (A: TimeoutCycles=16, CntWidth=8; B: TimeoutCycles=4, CntWidth=2, overlapping map).
module tb_bus_interconnect_tmo;
  localparam int DW = 32;
  localparam int NS = 4;

  localparam logic [NS*DW-1:0] BaseA = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000};
  localparam logic [NS*DW-1:0] MaskA = {32'hFFFF_0000, 32'hFFFE_0000, 32'hFFFF_0000, 32'hFFFF_0000};
  localparam logic [NS*DW-1:0] BaseB = {32'h5000_0000, 32'h4000_0000, 32'h0001_0000, 32'h0000_0000};
  localparam logic [NS*DW-1:0] MaskB = {32'hF000_0000, 32'hF000_0000, 32'hFFFF_0000, 32'hFF00_0000};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] addr;
  logic          trans;
  logic [DW-1:0] rdata [NS];
  logic [NS-1:0] resp;
  logic [NS-1:0] rdy;
  logic [7:0]    cnt_a;
  logic [1:0]    cnt_b;
  logic          tmo_a, tmo_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bus_interconnect_tmo_if #(.DWidth(DW), .NumofSlave(NS)) ifa ();
  bus_interconnect_tmo_if #(.DWidth(DW), .NumofSlave(NS)) ifb ();

  assign ifa.addr_i     = addr;
  assign ifb.addr_i     = addr;
  assign ifa.trans_i    = trans;
  assign ifb.trans_i    = trans;
  assign ifa.resp_i     = resp;
  assign ifb.resp_i     = resp;
  assign ifa.readyout_i = rdy;
  assign ifb.readyout_i = rdy;
  for (genvar g = 0; g < NS; g++) begin : g_rd
    assign ifa.rdata_i[g] = rdata[g];
    assign ifb.rdata_i[g] = rdata[g];
  end

  bus_interconnect_tmo #(
    .DWidth(DW), .NumofSlave(NS), .SlvBase(BaseA), .SlvMask(MaskA),
    .TimeoutCycles(16), .CntWidth(8)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .bus(ifa), .err_cnt_o(cnt_a), .tmo_o(tmo_a)
  );

  bus_interconnect_tmo #(
    .DWidth(DW), .NumofSlave(NS), .SlvBase(BaseB), .SlvMask(MaskB),
    .TimeoutCycles(4), .CntWidth(2)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .bus(ifb), .err_cnt_o(cnt_b), .tmo_o(tmo_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic chk_a(input string tag, input logic r, input logic rs, input logic [DW-1:0] d);
    chk({tag, ".rdy_a"},   64'(ifa.ready_o), 64'(r));
    chk({tag, ".resp_a"},  64'(ifa.resp_o),  64'(rs));
    chk({tag, ".rdata_a"}, 64'(ifa.rdata_o), 64'(d));
  endtask

  task automatic chk_b(input string tag, input logic r, input logic rs, input logic [DW-1:0] d);
    chk({tag, ".rdy_b"},   64'(ifb.ready_o), 64'(r));
    chk({tag, ".resp_b"},  64'(ifb.resp_o),  64'(rs));
    chk({tag, ".rdata_b"}, 64'(ifb.rdata_o), 64'(d));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    addr  = '0;
    trans = 1'b0;
    rdata = '{default: '0};
    resp  = '0;
    rdy   = '0;

    // Reset state and combinational decode while held in reset.
    #2;
    addr  = 32'h0001_0004;
    trans = 1'b1;
    #2;
    chk_a("rst", 1'b1, 1'b0, 32'h0);
    chk_b("rst", 1'b1, 1'b0, 32'h0);
    chk("rst.cnt_a", 64'(cnt_a), 64'd0);
    chk("rst.cnt_b", 64'(cnt_b), 64'd0);
    chk("rst.tmo_a", 64'(tmo_a), 64'd0);
    chk("rst.tmo_b", 64'(tmo_b), 64'd0);
    chk("rst.sel_a", 64'(ifa.sel_o), 64'b0010);
    chk("rst.sel_b", 64'(ifb.sel_o), 64'b0001);
    addr = 32'h0003_0008;
    #1;
    chk("ovl.sel_a", 64'(ifa.sel_o), 64'b0100);
    chk("ovl.sel_b", 64'(ifb.sel_o), 64'b0001);
    addr = 32'hFFFF_0000;
    #1;
    chk("unmap.sel_a", 64'(ifa.sel_o), 64'b0000);
    chk("unmap.sel_b", 64'(ifb.sel_o), 64'b0000);
    trans = 1'b0;
    addr  = 32'h0001_0004;
    #1;
    chk("notrans.sel_a", 64'(ifa.sel_o), 64'b0000);
    cyc();
    rst_n = 1'b1;

    // Zero-wait mapped read.
    cyc();
    addr     = 32'h0001_0004;
    trans    = 1'b1;
    rdy      = 4'hF;
    rdata[0] = 32'h1111_0000;
    rdata[1] = 32'hA5A5_A5A5;
    #4;
    chk("t1.sel_a", 64'(ifa.sel_o), 64'b0010);
    chk("t1.sel_b", 64'(ifb.sel_o), 64'b0001);
    cyc();
    trans = 1'b0;
    #4;
    chk_a("t1.data", 1'b1, 1'b0, 32'hA5A5_A5A5);
    chk_b("t1.data", 1'b1, 1'b0, 32'h1111_0000);

    // Three wait states, completing in the last non-timeout cycle for B.
    cyc();
    addr  = 32'h0000_0010;
    trans = 1'b1;
    rdy   = 4'b1110;
    #4;
    chk("t2.sel_a", 64'(ifa.sel_o), 64'b0001);
    chk("t2.sel_b", 64'(ifb.sel_o), 64'b0001);
    cyc();
    trans = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #4;
      chk($sformatf("t2.wait%0d.rdy_a", k), 64'(ifa.ready_o), 64'd0);
      chk($sformatf("t2.wait%0d.rdy_b", k), 64'(ifb.ready_o), 64'd0);
      cyc();
    end
    rdy[0]   = 1'b1;
    rdata[0] = 32'h2222_3333;
    #4;
    chk_a("t2.done", 1'b1, 1'b0, 32'h2222_3333);
    chk_b("t2.done", 1'b1, 1'b0, 32'h2222_3333);
    chk("t2.tmo_b", 64'(tmo_b), 64'd0);
    cyc();
    #4;
    chk("t2.idle.tmo_b", 64'(tmo_b), 64'd0);
    chk("t2.idle.cnt_b", 64'(cnt_b), 64'd0);

    // Unmapped address, then a mapped request pipelined into ERR2.
    cyc();
    addr     = 32'hFFFF_0000;
    trans    = 1'b1;
    rdata[0] = 32'hDEAD_BEEF;
    #4;
    chk("t3.sel_a", 64'(ifa.sel_o), 64'b0000);
    chk("t3.sel_b", 64'(ifb.sel_o), 64'b0000);
    cyc();
    addr = 32'h0001_0004;
    #4;
    chk_a("t3.err1", 1'b0, 1'b1, 32'h0);
    chk_b("t3.err1", 1'b0, 1'b1, 32'h0);
    chk("t3.err1.sel_a", 64'(ifa.sel_o), 64'b0000);
    cyc();
    #4;
    chk_a("t3.err2", 1'b1, 1'b1, 32'h0);
    chk_b("t3.err2", 1'b1, 1'b1, 32'h0);
    chk("t3.err2.cnt_a", 64'(cnt_a), 64'd0);
    chk("t3.err2.tmo_b", 64'(tmo_b), 64'd0);
    chk("t3.err2.sel_a", 64'(ifa.sel_o), 64'b0010);
    chk("t3.err2.sel_b", 64'(ifb.sel_o), 64'b0001);
    cyc();
    trans = 1'b0;
    #4;
    chk_a("t3.b2b", 1'b1, 1'b0, 32'hA5A5_A5A5);
    chk_b("t3.b2b", 1'b1, 1'b0, 32'hDEAD_BEEF);
    chk("t3.cnt_a", 64'(cnt_a), 64'd1);
    chk("t3.cnt_b", 64'(cnt_b), 64'd1);

    // Slave0 hangs: B times out after four wait cycles, A keeps waiting.
    cyc();
    addr  = 32'h0000_0020;
    trans = 1'b1;
    rdy   = 4'b1110;
    resp  = '0;
    #4;
    chk("t4.sel_a", 64'(ifa.sel_o), 64'b0001);
    cyc();
    trans = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #4;
      chk($sformatf("t4.wait%0d.rdy_a", k), 64'(ifa.ready_o), 64'd0);
      chk($sformatf("t4.wait%0d.rdy_b", k), 64'(ifb.ready_o), 64'd0);
      cyc();
    end
    #4;
    chk_b("t4.err1", 1'b0, 1'b1, 32'h0);
    chk("t4.err1.tmo_b", 64'(tmo_b), 64'd0);
    chk("t4.err1.rdy_a", 64'(ifa.ready_o), 64'd0);
    chk("t4.err1.resp_a", 64'(ifa.resp_o), 64'd0);
    cyc();
    rdy[0]   = 1'b1;
    resp[0]  = 1'b1;
    rdata[0] = 32'h1234_5678;
    #4;
    chk_b("t4.err2", 1'b1, 1'b1, 32'h0);
    chk("t4.err2.tmo_b", 64'(tmo_b), 64'd1);
    chk_a("t4.late", 1'b1, 1'b1, 32'h1234_5678);
    chk("t4.tmo_a", 64'(tmo_a), 64'd0);
    cyc();
    #4;
    chk_b("t4.ignored", 1'b1, 1'b0, 32'h0);
    chk("t4.after.tmo_b", 64'(tmo_b), 64'd0);
    chk("t4.cnt_a", 64'(cnt_a), 64'd1);
    chk("t4.cnt_b", 64'(cnt_b), 64'd2);
    rdy  = 4'hF;
    resp = '0;

    // Asynchronous reset while in ERR1.
    cyc();
    addr  = 32'hFFFF_0000;
    trans = 1'b1;
    cyc();
    trans = 1'b0;
    #3;
    chk_a("t6.err1", 1'b0, 1'b1, 32'h0);
    rst_n = 1'b0;
    #1;
    chk_a("t6.rst", 1'b1, 1'b0, 32'h0);
    chk_b("t6.rst", 1'b1, 1'b0, 32'h0);
    chk("t6.rst.cnt_a", 64'(cnt_a), 64'd0);
    chk("t6.rst.cnt_b", 64'(cnt_b), 64'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    chk("t6.rel.cnt_a", 64'(cnt_a), 64'd0);
    cyc();
    addr     = 32'h0001_0004;
    trans    = 1'b1;
    rdata[1] = 32'h5A5A_1234;
    #4;
    chk("t6.sel_a", 64'(ifa.sel_o), 64'b0010);
    cyc();
    trans = 1'b0;
    #4;
    chk_a("t6.after", 1'b1, 1'b0, 32'h5A5A_1234);
    chk("t6.after.cnt_a", 64'(cnt_a), 64'd0);

    // Five back-to-back unmapped transfers: B saturates at 3.
    cyc();
    addr  = 32'hFFFF_0000;
    trans = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      #4;
      chk($sformatf("t5.err1_%0d.rdy_b", k), 64'(ifb.ready_o), 64'd0);
      chk($sformatf("t5.err1_%0d.resp_b", k), 64'(ifb.resp_o), 64'd1);
      if (k >= 2) begin
        chk($sformatf("t5.cnt_a_%0d", k - 1), 64'(cnt_a), 64'(k - 1));
        chk($sformatf("t5.cnt_b_%0d", k - 1), 64'(cnt_b), (k - 1 > 3) ? 64'd3 : 64'(k - 1));
      end
      cyc();
      if (k == 5) trans = 1'b0;
      #4;
      chk($sformatf("t5.err2_%0d.rdy_b", k), 64'(ifb.ready_o), 64'd1);
    end
    cyc();
    #4;
    chk("t5.cnt_a_5", 64'(cnt_a), 64'd5);
    chk("t5.cnt_b_5", 64'(cnt_b), 64'd3);
    chk_b("t5.idle", 1'b1, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
